// File: rtl/sub8_if.sv
// sub8_if: start/done operand and result bundle for the serial subtractor
interface sub8_if #(parameter int WIDTH = 8) ();
    logic             start;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             bin;
    logic [WIDTH-1:0] d;
    logic             bout;
    logic             busy;
    logic             done;

    modport master (output start, x, y, bin, input d, bout, busy, done);
    modport slave  (input start, x, y, bin, output d, bout, busy, done);
endinterface

// File: rtl/sub8_serial.sv
// sub8_serial: bit-serial LSB-first subtractor d = x - y - bin with borrow-out
module sub8_serial #(
    parameter int WIDTH = 8,
    parameter int CW    = 4
) (
    input logic   clk,
    input logic   rst_n,
    sub8_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_sr, b_sr, r_sr, d_q;
    logic [CW-1:0]    cnt;
    logic             brw, bout_q, done_q, busy, diff, brw_nx, last;

    // next state, busy flag and one full-subtractor bit slice
    always_comb begin
        diff     = a_sr[0] ^ b_sr[0] ^ brw;
        brw_nx   = (~a_sr[0] & b_sr[0]) | (~a_sr[0] & brw) | (b_sr[0] & brw);
        last     = cnt == CW'(WIDTH - 1);
        busy     = state == RUN;
        state_nx = IDLE;
        case (state)
            IDLE:    state_nx = bus.start ? RUN : IDLE;
            RUN:     state_nx = last ? DONE : RUN;
            default: state_nx = IDLE;
        endcase
    end

    // state register, operand shifters and result registers updated on leaving DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            r_sr   <= '0;
            cnt    <= '0;
            brw    <= 1'b0;
            d_q    <= '0;
            bout_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nx;
            done_q <= state == DONE;
            if (state == IDLE && bus.start) begin
                a_sr <= bus.x;
                b_sr <= bus.y;
                brw  <= bus.bin;
                r_sr <= '0;
                cnt  <= '0;
            end else if (state == RUN) begin
                a_sr <= a_sr >> 1;
                b_sr <= b_sr >> 1;
                r_sr <= {diff, r_sr[WIDTH-1:1]};
                brw  <= brw_nx;
                cnt  <= last ? '0 : cnt + 1'b1;
            end
            if (state == DONE) begin
                d_q    <= r_sr;
                bout_q <= brw;
            end
        end
    end

    assign bus.d    = d_q;
    assign bus.bout = bout_q;
    assign bus.busy = busy;
    assign bus.done = done_q;
endmodule
